// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the main-BSRAM two-master arbiter.
package ram_arb_pkg;

   localparam int RAM_AW = 13;
   localparam int RAM_DW = 8;

   typedef enum logic {
      MID_CPU = 1'b0,
      MID_AUX = 1'b1
   } master_id_t;

   typedef struct packed {
      logic       valid;
      master_id_t id;
   } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-return tag shift register: one {valid, id} entry per cycle of read latency.
module rd_tag_pipe
   import ram_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst_n,
   input  rd_tag_t push_tag,
   output rd_tag_t tail_tag
);

   rd_tag_t [DEPTH-1:0] tag_q;
   rd_tag_t [DEPTH-1:0] tag_d;

   // Shift every cycle; a non-read cycle pushes an invalid tag.
   always_comb begin
      tag_d = {tag_q[DEPTH-2:0], push_tag};
   end

   // Tag storage; reset drops every in-flight read so it never returns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_q <= '0;
      end else begin
         tag_q <= tag_d;
      end
   end

   assign tail_tag = tag_q[DEPTH-1];

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter issuing one access per cycle from two masters to the main BSRAM.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int AW     = RAM_AW,
   parameter int DW     = RAM_DW,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic          cea,
   output logic [AW-1:0] ada,
   output logic [DW-1:0] din,
   output logic          ceb,
   output logic [AW-1:0] adb,
   input  logic [DW-1:0] dout
);

   master_id_t    last_q, last_d;
   logic          cea_q, cea_d;
   logic          ceb_q, ceb_d;
   logic [AW-1:0] ada_q, ada_d;
   logic [AW-1:0] adb_q, adb_d;
   logic [DW-1:0] din_q, din_d;

   logic          any_gnt;
   master_id_t    sel_id;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   rd_tag_t       push_tag;
   rd_tag_t       tail_tag;

   // Grant: a lone requester wins; on conflict the master not granted last wins.
   always_comb begin
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
      if (m0_req && m1_req) begin
         if (last_q == MID_AUX) begin
            m0_gnt = 1'b1;
         end else begin
            m1_gnt = 1'b1;
         end
      end else begin
         m0_gnt = m0_req;
         m1_gnt = m1_req;
      end
      any_gnt   = m0_gnt | m1_gnt;
      sel_id    = m1_gnt ? MID_AUX : MID_CPU;
      sel_we    = m1_gnt ? m1_we : m0_we;
      sel_addr  = m1_gnt ? m1_addr : m0_addr;
      sel_wdata = m1_gnt ? m1_wdata : m0_wdata;
   end

   // Next RAM command: enables are one-cycle pulses, address/data hold when idle.
   always_comb begin
      last_d         = last_q;
      cea_d          = 1'b0;
      ceb_d          = 1'b0;
      ada_d          = ada_q;
      adb_d          = adb_q;
      din_d          = din_q;
      push_tag.valid = 1'b0;
      push_tag.id    = MID_CPU;
      if (any_gnt) begin
         last_d = sel_id;
         if (sel_we) begin
            cea_d = 1'b1;
            ada_d = sel_addr;
            din_d = sel_wdata;
         end else begin
            ceb_d          = 1'b1;
            adb_d          = sel_addr;
            push_tag.valid = 1'b1;
            push_tag.id    = sel_id;
         end
      end
   end

   // Round-robin pointer and RAM command registers; reset favours m0 on first conflict.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= MID_AUX;
         cea_q  <= 1'b0;
         ceb_q  <= 1'b0;
         ada_q  <= '0;
         adb_q  <= '0;
         din_q  <= '0;
      end else begin
         last_q <= last_d;
         cea_q  <= cea_d;
         ceb_q  <= ceb_d;
         ada_q  <= ada_d;
         adb_q  <= adb_d;
         din_q  <= din_d;
      end
   end

   // Tag reaches the tail in the cycle the RAM presents the read data.
   rd_tag_pipe #(
      .DEPTH (RD_LAT + 1)
   ) u_tag_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_tag (push_tag),
      .tail_tag (tail_tag)
   );

   assign cea       = cea_q;
   assign ceb       = ceb_q;
   assign ada       = ada_q;
   assign adb       = adb_q;
   assign din       = din_q;
   assign m0_rvalid = tail_tag.valid && (tail_tag.id == MID_CPU);
   assign m1_rvalid = tail_tag.valid && (tail_tag.id == MID_AUX);
   assign m0_rdata  = dout;
   assign m1_rdata  = dout;

endmodule
